// File: rtl/nonce_sweep_scheduler_if.sv
// Handshake bundle between the nonce sweep scheduler and its environment.
// The block's master drives start/abort and returns results; the scheduler is the slave.
interface nonce_sweep_scheduler_if #(
    parameter int NCORES  = 4,
    parameter int NONCE_W = 32
);
    logic               start;
    logic               abort;
    logic               nonce_valid;
    logic [NONCE_W-1:0] nonce_base;
    logic               res_valid;
    logic [NCORES-1:0]  res_hit;
    logic               found_valid;
    logic               found;
    logic [NONCE_W-1:0] found_nonce;
    logic               busy;
    logic               err_underflow;

    modport master (
        output start, abort, res_valid, res_hit,
        input  nonce_valid, nonce_base, found_valid, found, found_nonce, busy, err_underflow
    );

    modport slave (
        input  start, abort, res_valid, res_hit,
        output nonce_valid, nonce_base, found_valid, found, found_nonce, busy, err_underflow
    );
endinterface

// File: rtl/nonce_sweep_scheduler.sv
// Issues nonce batches to the hashing cores once per round, tracks in-flight batches
// in a tag FIFO and reports the first winning nonce or exhaustion of the nonce space.
module nonce_sweep_scheduler #(
    parameter int NCORES       = 4,
    parameter int NCYCLES      = 64,
    parameter int NONCE_W      = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    nonce_sweep_scheduler_if.slave bus
);
    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CNT_W = (NCYCLES > 1) ? $clog2(NCYCLES) : 1;
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int DEPTH = 1 << PTR_W;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [NONCE_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               found_valid_q, found_valid_d;
    logic               found_q, found_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic               err_q, err_d;
    logic [NONCE_W-1:0] fifo_mem_q [DEPTH];

    logic               issue, push, pop, hit, flush;
    logic               fifo_empty, fifo_full, active;
    logic [NONCE_W:0]   base_sum;
    logic [IDX_W-1:0]   hit_idx;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W+1)'(MAX_INFLIGHT));
    assign base_sum   = {1'b0, base_q} + (NONCE_W+1)'(NCORES);
    assign active     = (state_q == DISPATCH) || (state_q == DRAIN);

    // Lowest set bit of the hit mask selects the winning core.
    always_comb begin
        hit_idx = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (bus.res_hit[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        found_valid_d = 1'b0;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        err_d         = err_q;
        issue         = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        hit           = 1'b0;
        flush         = 1'b0;

        if (bus.abort) begin
            state_d       = IDLE;
            base_d        = '0;
            cnt_d         = '0;
            found_d       = 1'b0;
            found_nonce_d = '0;
            flush         = 1'b1;
        end else if (bus.start) begin
            // Restart from any state discards whatever the old block had in flight.
            state_d       = DISPATCH;
            base_d        = '0;
            cnt_d         = '0;
            found_d       = 1'b0;
            found_nonce_d = '0;
            flush         = 1'b1;
        end else if (active) begin
            issue = (state_q == DISPATCH) && (cnt_q == '0) && !fifo_full;
            if ((state_q == DISPATCH) && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (issue) begin
                push  = 1'b1;
                cnt_d = CNT_W'(NCYCLES - 1);
                if (base_sum[NONCE_W]) begin
                    state_d = DRAIN;
                end else begin
                    base_d = base_sum[NONCE_W-1:0];
                end
            end
            if (bus.res_valid) begin
                if (fifo_empty) begin
                    err_d = 1'b1;
                end else begin
                    pop = 1'b1;
                    hit = |bus.res_hit;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (PTR_W+1)'(1);
            end

            // A hit wins even over a same-cycle issue; that batch is flushed with the rest.
            if (hit) begin
                state_d       = DONE;
                found_valid_d = 1'b1;
                found_d       = 1'b1;
                found_nonce_d = fifo_mem_q[rd_ptr_q] + NONCE_W'(hit_idx);
                flush         = 1'b1;
            end else if ((state_q == DRAIN) && (count_d == '0)) begin
                state_d       = DONE;
                found_valid_d = 1'b1;
                found_d       = 1'b0;
                found_nonce_d = '0;
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            found_valid_q <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            found_valid_q <= found_valid_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= base_q;
        end
    end

    assign bus.nonce_valid   = issue;
    assign bus.nonce_base    = base_q;
    assign bus.found_valid   = found_valid_q;
    assign bus.found         = found_q;
    assign bus.found_nonce   = found_nonce_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.err_underflow = err_q;
endmodule

// File: doc/nonce_sweep_scheduler.md
Name: nonce_sweep_scheduler

Overview:
- Sequences the nonce sweep for the block currently held in block storage and broadcast to the hashing cores.
- On each new block it issues nonce batches to NCORES parallel cores, one batch every NCYCLES cycles, matching the broadcast round period.
- It tracks in-flight batches in a tag FIFO and matches returned per-batch hit masks to their nonce bases.
- It reports the first winning nonce, or reports exhaustion of the nonce space.

Parameters:
- NCORES, 4: cores per batch; batch covers nonces base..base+NCORES-1; power of two.
- NCYCLES, 64: cycles between batch issues, equal to the core round count.
- NONCE_W, 32: nonce width.
- MAX_INFLIGHT, 4: depth of the in-flight tag FIFO; power of two.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse: new block loaded into broadcast (driven from newblock).
- abort  in  1  pulse: discard the current sweep.
- nonce_valid  out  1  one-cycle pulse: batch issued this cycle.
- nonce_base  out  NONCE_W  base nonce of the issued batch.
- res_valid  in  1  one strobe per batch, in issue order.
- res_hit  in  NCORES  hit mask for the oldest in-flight batch; bit i means nonce base+i.
- found_valid  out  1  one-cycle pulse: sweep finished.
- found  out  1  1 = hit found, 0 = nonce space exhausted; valid with found_valid.
- found_nonce  out  NONCE_W  winning nonce; 0 when found=0.
- busy  out  1  state is not IDLE.
- err_underflow  out  1  sticky: res_valid arrived with the FIFO empty.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; base=0; period counter=0; FIFO empty.
- Outputs on reset: all outputs 0, including err_underflow.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE: wait for start. On start: base=0, cnt=0, FIFO cleared, go to DISPATCH.
- DISPATCH, issue condition: cnt==0 and FIFO not full.
- DISPATCH, on issue:
  - nonce_valid=1 combinationally, nonce_base=base.
  - base is pushed into the FIFO.
  - base+=NCORES, computed at NONCE_W+1 bits.
  - cnt=NCYCLES-1.
- DISPATCH, other cycles: cnt decrements while >0. FIFO full with cnt==0 stalls the issue; cnt stays 0.
- First batch issues in the cycle after start is sampled, then every NCYCLES cycles absent stalls.
- Last batch: if base+NCORES carries out of NONCE_W bits, that issue is the final one and the state moves to DRAIN. Base is not advanced past the carry.
- Result handling (DISPATCH or DRAIN), on res_valid with FIFO non-empty:
  - Pop the head tag.
  - If res_hit≠0, take the lowest set bit index i and register found_nonce=tag+i, found=1.
  - Pulse found_valid the next cycle and go to DONE; further issue stops.
- Push and pop in the same cycle are both honoured; FIFO occupancy is unchanged.
- DRAIN: no issues. When the FIFO becomes empty without a hit, pulse found_valid with found=0, found_nonce=0, and go to DONE.
- DONE: nonce_valid stays 0; res_valid is ignored with no pop and no error. The next start restarts from IDLE semantics.
- Underflow: res_valid with the FIFO empty in any state except DONE/IDLE sets err_underflow. Only reset clears it. Otherwise ignored.
- abort (any state): next cycle state IDLE, FIFO cleared, no found_valid.
- abort has priority over start and over res_valid in the same cycle.
- start while busy (without abort): restart, treated as abort+start. The FIFO is cleared, and the pending hit from the old block in that cycle is discarded.
- found_valid and nonce_valid are never both 1 after a hit: a hit popped in the same cycle as an issue still finishes the sweep. The just-issued batch is flushed by the transition to DONE.
- busy = (state≠IDLE), DONE included, until the next abort or start.

Test Plan:
- Basic sweep timing (NCYCLES=4, NCORES=4): start at cycle 0 → nonce_valid in cycles 1, 5, 9 with nonce_base 0, 4, 8.
- Hit decode: after 2 issues, res_valid with mask 0000, then res_valid with mask 0110 → found_valid one cycle later, found=1, found_nonce=5 (tag 4 + lowest bit 1); no further nonce_valid.
- FIFO stall: MAX_INFLIGHT=2, no res_valid → exactly 2 issues. A single res_valid (mask 0) → the third issue occurs in the next cycle.
- Exhaustion (NONCE_W=4, NCORES=4): 4 issues with bases 0, 4, 8, 12, then DRAIN. Four res_valid with mask 0 → found_valid with found=0, found_nonce=0.
- Abort priority: abort asserted together with a res_valid carrying a hit → no found_valid, busy=0 next cycle. A following start issues base 0.
- Underflow and async reset:
  - res_valid in DISPATCH with the FIFO empty → err_underflow=1, held until reset.
  - Drop rst mid-DRAIN → all outputs 0 immediately, without waiting for a clock edge.
